// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 16-bit LED image with per-bit blinking.
// CPU writes land in a shadow image. The shadow image is copied to the
// display image only at a driver frame boundary, so a frame that is being
// shifted out never changes part-way through. The blink phase is timed by
// counting frame boundaries.
module led_frame_buffer #(
    parameter int BLINK_FRAMES = 64,
    parameter int BLINK_W      = 8
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_WrEn,
    input  logic        i_WrSel,
    input  logic [1:0]  i_ByteEn,
    input  logic [15:0] i_WrData,
    input  logic        i_Commit,
    input  logic        i_FrameSync,
    output logic [15:0] o_Data16,
    output logic        o_Pending,
    output logic        o_BlinkPhase
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [BLINK_W-1:0] CNT_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [15:0]        shadow;
    logic [15:0]        display;
    logic [15:0]        mask;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               swap;
    logic               wr_shadow;
    logic               wr_mask;

    // Decode the write target and the swap event for this cycle.
    always_comb begin
        wr_shadow = i_WrEn & ~i_WrSel;
        wr_mask   = i_WrEn &  i_WrSel;
        swap      = (state == ST_PENDING) & i_FrameSync;
    end

    // Commit handshake: a commit waits for the next frame boundary; extra
    // commits while waiting are absorbed, and a commit that arrives in the
    // swap cycle is absorbed too.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (i_Commit)    state_next = ST_PENDING;
            ST_PENDING: if (i_FrameSync) state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Shadow image: byte-enabled CPU writes.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            shadow <= '0;
        end else if (wr_shadow) begin
            if (i_ByteEn[0]) shadow[7:0]  <= i_WrData[7:0];
            if (i_ByteEn[1]) shadow[15:8] <= i_WrData[15:8];
        end
    end

    // Display image: takes the pre-write shadow value at a pending frame boundary.
    always_ff @(posedge i_CLK) begin
        if (i_RESET)   display <= '0;
        else if (swap) display <= shadow;
    end

    // Blink mask: byte-enabled writes, effective immediately.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            mask <= '0;
        end else if (wr_mask) begin
            if (i_ByteEn[0]) mask[7:0]  <= i_WrData[7:0];
            if (i_ByteEn[1]) mask[15:8] <= i_WrData[15:8];
        end
    end

    // Blink timing: count frame boundaries, toggle phase on each wrap.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (i_FrameSync) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Outputs come straight from registers, so they are stable all cycle.
    always_comb begin
        o_Data16     = display & ~(mask & {16{~blink_phase}});
        o_Pending    = (state == ST_PENDING);
        o_BlinkPhase = blink_phase;
    end

endmodule
